// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads to instruction memory under a credit
// limit, buffers returned words with their PC and hands them to decode via valid/ready.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] live, drop, count;
    logic [31:0]   buf_pc   [DEPTH];
    logic [31:0]   buf_word [DEPTH];
    logic [31:0]   iss_pc   [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, iss_rd, iss_wr;
    logic [CW+1:0] used;
    logic          pop, accept, keep;
    logic          unused_bits;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign unused_bits = &{1'b0, redirect_pc[1:0]};

    assign pop       = out_valid & out_ready & ~redirect;
    assign used      = (CW + 2)'(live) + (CW + 2)'(drop) + (CW + 2)'(count);
    // A slot freed by this cycle's pop is reusable at once, so a next-cycle memory
    // sustains one instruction per cycle with two entries.
    assign imem_req  = rst_n & ~redirect & (used < DEPTH_W + (CW + 2)'(pop));
    assign imem_addr = pc;
    assign accept    = imem_req & imem_ready;
    assign keep      = imem_rvalid & (drop == '0);

    assign out_valid       = (count != '0);
    assign out_pc          = buf_pc[rd_ptr];
    assign out_instruction = buf_word[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            live   <= '0;
            drop   <= '0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            iss_rd <= '0;
            iss_wr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]   <= '0;
                buf_word[i] <= '0;
                iss_pc[i]   <= '0;
            end
        end else if (redirect) begin
            // Everything outstanding becomes a drop; a response landing now is one less.
            pc     <= {redirect_pc[31:2], 2'b00};
            drop   <= drop + live - CW'(imem_rvalid);
            live   <= '0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            iss_rd <= '0;
            iss_wr <= '0;
        end else begin
            if (accept) begin
                pc             <= pc + 32'd4;
                iss_pc[iss_wr] <= pc;
                iss_wr         <= inc(iss_wr);
            end
            if (imem_rvalid && drop != '0)
                drop <= drop - CW'(1);
            if (keep) begin
                buf_pc[wr_ptr]   <= iss_pc[iss_rd];
                buf_word[wr_ptr] <= imem_rdata;
                wr_ptr           <= inc(wr_ptr);
                iss_rd           <= inc(iss_rd);
            end
            if (pop)
                rd_ptr <= inc(rd_ptr);
            live  <= live + CW'(accept) - CW'(keep);
            count <= count + CW'(keep) - CW'(pop);
        end
    end

    always @(posedge clk) begin
        if (rst_n)
            assert (!(imem_rvalid && live == '0 && drop == '0))
                else $error("imem_rvalid with no outstanding request");
    end
endmodule
